// File: rtl/seq_pattern_detector_if.sv
// Configuration and serial-stream bundle for seq_pattern_detector.
// The master drives the stream and configuration. The slave (the detector) returns the match outputs.
interface seq_pattern_detector_if #(
    parameter int PAT_LEN = 3,
    parameter int CNT_W   = 8
);
    logic               cfg_load;
    logic [PAT_LEN-1:0] cfg_pattern;
    logic               cfg_overlap;
    logic               count_clr;
    logic               in_valid;
    logic               in;
    logic               out;
    logic [CNT_W-1:0]   match_count;
    logic               armed;

    modport master (
        output cfg_load, cfg_pattern, cfg_overlap, count_clr, in_valid, in,
        input  out, match_count, armed
    );

    modport slave (
        input  cfg_load, cfg_pattern, cfg_overlap, count_clr, in_valid, in,
        output out, match_count, armed
    );
endinterface

// File: rtl/seq_pattern_detector.sv
// Serial pattern detector with a loadable pattern and a selectable overlap mode.
// It produces a registered match pulse and keeps a saturating match counter.
module seq_pattern_detector #(
    parameter int PAT_LEN = 3,
    parameter int CNT_W   = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    seq_pattern_detector_if.slave bus
);
    localparam int FW = $clog2(PAT_LEN + 1);
    localparam logic [FW-1:0]    FILL_FULL = FW'(PAT_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic {UNPROG = 1'b0, RUN = 1'b1} state_t;

    state_t             state_reg, state_next;
    logic [PAT_LEN-1:0] pattern_reg, hist_reg, hist_shift;
    logic               overlap_reg, out_reg, armed_comb;
    logic [FW-1:0]      fill_reg, fill_inc;
    logic [CNT_W-1:0]   count_reg;
    logic               shift_en, match;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_reg <= UNPROG;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (bus.cfg_load) state_next = RUN;
    end

    always_comb begin
        armed_comb = (state_reg == RUN);
    end

    // A load edge takes priority over any valid bit presented on the same edge.
    always_comb begin
        shift_en   = armed_comb && bus.in_valid && !bus.cfg_load;
        hist_shift = {hist_reg[PAT_LEN-2:0], bus.in};
        fill_inc   = (fill_reg == FILL_FULL) ? FILL_FULL : fill_reg + 1'b1;
        match      = shift_en && (fill_inc == FILL_FULL) && (hist_shift == pattern_reg);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pattern_reg <= '0;
            overlap_reg <= 1'b0;
            hist_reg    <= '0;
            fill_reg    <= '0;
            out_reg     <= 1'b0;
        end else if (bus.cfg_load) begin
            pattern_reg <= bus.cfg_pattern;
            overlap_reg <= bus.cfg_overlap;
            hist_reg    <= '0;
            fill_reg    <= '0;
            out_reg     <= 1'b0;
        end else if (shift_en) begin
            hist_reg <= hist_shift;
            // Non-overlapping mode restarts the fill so the next match needs fresh bits.
            fill_reg <= (match && !overlap_reg) ? '0 : fill_inc;
            out_reg  <= match;
        end else begin
            out_reg <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                            count_reg <= '0;
        else if (bus.count_clr)                count_reg <= '0;
        else if (match && count_reg != CNT_MAX) count_reg <= count_reg + 1'b1;
    end

    assign bus.out         = out_reg;
    assign bus.match_count = count_reg;
    assign bus.armed       = armed_comb;
endmodule
